gpu_rect_fill: RTL and testbench

- Hardware rectangle-fill engine that sits directly upstream of the GPU's VRAM write port (write-enable, 15-bit address, 8-bit data).
- The CPU programs origin, size and colour, then pulses start. The engine streams one pixel write per clock into the 200x150 framebuffer (address = y*200 + x), clipping the rectangle to the screen.
- When the engine is idle, CPU direct VRAM writes pass straight through.

---
 rtl/gpu_rect_fill.sv | 144 ++++++++++++++
 tb/tb_gpu_rect_fill.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine in front of the VRAM write port. It streams one pixel
// write per clock over the rectangle clipped to the framebuffer and lets CPU
// writes pass straight through while idle.
module gpu_rect_fill #(
    parameter int H_RES = 200,
    parameter int V_RES = 150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  x0_i,
    input  logic [7:0]  y0_i,
    input  logic [7:0]  w_i,
    input  logic [7:0]  h_i,
    input  logic [7:0]  color_i,
    input  logic        cpu_we_i,
    input  logic [14:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cpu_stall_o,
    output logic        v_we_o,
    output logic [14:0] v_addr_o,
    output logic [7:0]  v_data_o
);

    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [8:0]  H_LIM = 9'(H_RES);
    localparam logic [8:0]  V_LIM = 9'(V_RES);
    localparam logic [14:0] H_STEP = 15'(H_RES);

    state_t      state, state_next;

    logic [7:0]  x0_q, y0_q, w_q, h_q, color_q;
    logic [8:0]  xe_q, ye_q, col_q, row_q;
    logic [14:0] row_base_q, addr_q;

    // Setup-time geometry: 9-bit sums so x0+w and y0+h never wrap
    logic [8:0]  x_sum, y_sum, xe_calc, ye_calc;
    logic [14:0] base_calc;
    logic        empty, col_end, last_write;

    // Clipped extents, emptiness test and first address of the rectangle
    always_comb begin
        x_sum     = {1'b0, x0_q} + {1'b0, w_q};
        y_sum     = {1'b0, y0_q} + {1'b0, h_q};
        xe_calc   = (x_sum > H_LIM) ? H_LIM : x_sum;
        ye_calc   = (y_sum > V_LIM) ? V_LIM : y_sum;
        empty     = ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM) ||
                    (w_q == 8'd0) || (h_q == 8'd0);
        // The only multiply; it happens once per fill, never per pixel
        base_calc = 15'(y0_q) * H_STEP + 15'(x0_q);
        col_end   = (col_q == xe_q - 9'd1);
        last_write = col_end && (row_q == ye_q - 9'd1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and output steering between CPU and engine
    always_comb begin
        state_next  = state;
        busy_o      = (state != IDLE);
        done_o      = 1'b0;
        cpu_stall_o = cpu_we_i;
        v_we_o      = 1'b0;
        v_addr_o    = addr_q;
        v_data_o    = color_q;
        case (state)
            IDLE: begin
                cpu_stall_o = 1'b0;
                v_we_o      = cpu_we_i;
                v_addr_o    = cpu_addr_i;
                v_data_o    = cpu_data_i;
                if (start_i) state_next = SETUP;
            end
            SETUP: state_next = empty ? DONE : FILL;
            FILL: begin
                v_we_o = 1'b1;
                if (last_write) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Parameter latch, raster counters and the registered engine address
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        x0_q    <= x0_i;
                        y0_q    <= y0_i;
                        w_q     <= w_i;
                        h_q     <= h_i;
                        color_q <= color_i;
                    end
                end
                SETUP: begin
                    xe_q       <= xe_calc;
                    ye_q       <= ye_calc;
                    col_q      <= {1'b0, x0_q};
                    row_q      <= {1'b0, y0_q};
                    row_base_q <= base_calc;
                    addr_q     <= base_calc;
                end
                FILL: begin
                    // addr_q tracks row_base + (col - x0) incrementally
                    if (col_end) begin
                        col_q      <= {1'b0, x0_q};
                        row_q      <= row_q + 9'd1;
                        row_base_q <= row_base_q + H_STEP;
                        addr_q     <= row_base_q + H_STEP;
                    end else begin
                        col_q  <= col_q + 9'd1;
                        addr_q <= addr_q + 15'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_rect_fill.sv
// Directed testbench for gpu_rect_fill.
module tb_gpu_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  x0_i, y0_i, w_i, h_i, color_i;
    logic        cpu_we_i;
    logic [14:0] cpu_addr_i;
    logic [7:0]  cpu_data_i;
    logic        busy_o, done_o, cpu_stall_o, v_we_o;
    logic [14:0] v_addr_o;
    logic [7:0]  v_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    int wa[$];
    int wd[$];
    int wc[$];
    int oob;

    gpu_rect_fill #(.H_RES(200), .V_RES(150)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .x0_i        (x0_i),
        .y0_i        (y0_i),
        .w_i         (w_i),
        .h_i         (h_i),
        .color_i     (color_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cpu_stall_o (cpu_stall_o),
        .v_we_o      (v_we_o),
        .v_addr_o    (v_addr_o),
        .v_data_o    (v_data_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then record every VRAM write (cycle index k counted from
    // the edge that sampled start) until done_o, bounded by budget.
    task automatic run_fill(input int x0, input int y0, input int w, input int h,
                            input int c, input int budget,
                            output int done_cyc, output int busy_bad);
        wa.delete(); wd.delete(); wc.delete();
        oob = 0;
        x0_i = 8'(x0); y0_i = 8'(y0); w_i = 8'(w); h_i = 8'(h); color_i = 8'(c);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        done_cyc = -1;
        busy_bad = 0;
        for (int k = 1; k <= budget; k++) begin
            if (v_we_o === 1'b1) begin
                wa.push_back(int'(v_addr_o));
                wd.push_back(int'(v_data_o));
                wc.push_back(k);
                if (v_addr_o >= 15'd30000) oob++;
            end
            if (busy_o !== 1'b1) busy_bad++;
            if (done_o === 1'b1) begin
                done_cyc = k;
                if (v_we_o !== 1'b0) busy_bad++;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        x0_i = '0; y0_i = '0; w_i = '0; h_i = '0; color_i = '0;
        tick(); tick();
        n_checks++;
        if ({busy_o, done_o, cpu_stall_o, v_we_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/done/stall/we=%b expected 0000",
                     {busy_o, done_o, cpu_stall_o, v_we_o});
        end
        rst = 1'b0;
        tick();
        cpu_we_i = 1'b1; cpu_addr_i = 15'd29999; cpu_data_i = 8'hA5;
        #1;
        n_checks++;
        if (v_we_o !== 1'b1 || v_addr_o !== 15'd29999 || v_data_o !== 8'hA5 || cpu_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_passthrough: we=%b addr=%0d data=%h stall=%b expected 1 29999 a5 0",
                     v_we_o, v_addr_o, v_data_o, cpu_stall_o);
        end
        cpu_we_i = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int exp_a[6] = '{1010, 1011, 1012, 1210, 1211, 1212};
        int dc, bb;
        run_fill(10, 5, 3, 2, 8'hE0, 50, dc, bb);
        n_checks++;
        if (wa.size() != 6) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes expected 6", wa.size());
        end
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            n_checks++;
            if (wa[i] != exp_a[i] || wd[i] != 8'hE0 || wc[i] != 2 + i) begin
                n_fail++;
                $display("FAIL basic_write%0d: addr=%0d data=%h cyc=%0d expected %0d e0 %0d",
                         i, wa[i], wd[i], wc[i], exp_a[i], 2 + i);
            end
        end
        n_checks++;
        if (dc != 8) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d expected 8", dc);
        end
        n_checks++;
        if (bb != 0) begin
            n_fail++;
            $display("FAIL basic_busy: %0d bad busy cycles expected 0", bb);
        end
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_done: busy=%b done=%b expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_clip();
        int exp_a[4] = '{29798, 29799, 29998, 29999};
        int dc, bb;
        run_fill(198, 148, 5, 5, 8'h1C, 50, dc, bb);
        n_checks++;
        if (wa.size() != 4) begin
            n_fail++;
            $display("FAIL clip_count: got %0d writes expected 4", wa.size());
        end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            n_checks++;
            if (wa[i] != exp_a[i] || wd[i] != 8'h1C || wc[i] != 2 + i) begin
                n_fail++;
                $display("FAIL clip_write%0d: addr=%0d data=%h cyc=%0d expected %0d 1c %0d",
                         i, wa[i], wd[i], wc[i], exp_a[i], 2 + i);
            end
        end
        n_checks++;
        if (oob != 0 || dc != 6) begin
            n_fail++;
            $display("FAIL clip_bounds_done: oob=%0d done_cyc=%0d expected 0 6", oob, dc);
        end
    endtask

    task automatic test_empty();
        int dc, bb;
        run_fill(10, 5, 0, 4, 8'hFF, 20, dc, bb);
        n_checks++;
        if (wa.size() != 0 || dc != 2 || bb != 0) begin
            n_fail++;
            $display("FAIL empty_w0: writes=%0d done_cyc=%0d busybad=%0d expected 0 2 0", wa.size(), dc, bb);
        end
        run_fill(200, 5, 4, 4, 8'hFF, 20, dc, bb);
        n_checks++;
        if (wa.size() != 0 || dc != 2 || bb != 0) begin
            n_fail++;
            $display("FAIL empty_x200: writes=%0d done_cyc=%0d busybad=%0d expected 0 2 0", wa.size(), dc, bb);
        end
    endtask

    task automatic test_cpu_arbitration();
        int exp_a[6] = '{1010, 1011, 1012, 1210, 1211, 1212};
        int nwr = 0, bad_wr = 0, bad_stall = 0, done_cyc = -1, addr_bad = 0;
        x0_i = 8'd10; y0_i = 8'd5; w_i = 8'd3; h_i = 8'd2; color_i = 8'hE0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cpu_we_i = 1'b1; cpu_addr_i = 15'h0123; cpu_data_i = 8'h55;
        #1;
        for (int k = 1; k <= 50; k++) begin
            if (k == 3) begin
                start_i = 1'b1; x0_i = 8'd0; y0_i = 8'd0; w_i = 8'd50; color_i = 8'h11;
                #1;
            end
            if (k == 4) start_i = 1'b0;
            if (cpu_stall_o !== 1'b1) bad_stall++;
            if (v_we_o === 1'b1) begin
                if (v_addr_o == 15'h0123 || v_data_o != 8'hE0) bad_wr++;
                if (nwr < 6 && int'(v_addr_o) != exp_a[nwr]) addr_bad++;
                nwr++;
            end
            if (done_o === 1'b1) begin
                done_cyc = k;
                break;
            end
            tick();
        end
        n_checks++;
        if (bad_stall != 0 || bad_wr != 0) begin
            n_fail++;
            $display("FAIL arb_stall: stall_bad=%0d leaked_writes=%0d expected 0 0", bad_stall, bad_wr);
        end
        n_checks++;
        if (nwr != 6 || addr_bad != 0 || done_cyc != 8) begin
            n_fail++;
            $display("FAIL arb_fill_unchanged: writes=%0d addr_bad=%0d done_cyc=%0d expected 6 0 8",
                     nwr, addr_bad, done_cyc);
        end
        tick();
        n_checks++;
        if (v_we_o !== 1'b1 || v_addr_o !== 15'h0123 || v_data_o !== 8'h55 || cpu_stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_release: we=%b addr=%h data=%h stall=%b expected 1 0123 55 0",
                     v_we_o, v_addr_o, v_data_o, cpu_stall_o);
        end
        cpu_we_i = 1'b0;
        tick();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_ignored_start: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_full_screen();
        int dc, bb, bad = 0;
        run_fill(0, 0, 255, 255, 8'h03, 30100, dc, bb);
        n_checks++;
        if (wa.size() != 30000) begin
            n_fail++;
            $display("FAIL full_count: got %0d writes expected 30000", wa.size());
        end
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] != i || wd[i] != 8'h03 || wc[i] != 2 + i) bad++;
        n_checks++;
        if (bad != 0 || oob != 0 || dc != 30002 || bb != 0) begin
            n_fail++;
            $display("FAIL full_order: bad=%0d oob=%0d done_cyc=%0d busybad=%0d expected 0 0 30002 0",
                     bad, oob, dc, bb);
        end
    endtask

    task automatic test_reset_mid_fill();
        int dc, bb, bad = 0;
        x0_i = 8'd10; y0_i = 8'd5; w_i = 8'd3; h_i = 8'd2; color_i = 8'hE0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (v_we_o !== 1'b1 || v_addr_o !== 15'd1012) begin
            n_fail++;
            $display("FAIL rstmid_third_write: we=%b addr=%0d expected 1 1012", v_we_o, v_addr_o);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (v_we_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_abort: we=%b busy=%b done=%b expected 0 0 0", v_we_o, busy_o, done_o);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done_o !== 1'b0 || v_we_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: %0d cycles with activity expected 0", bad);
        end
        run_fill(10, 5, 3, 2, 8'hE0, 50, dc, bb);
        n_checks++;
        if (wa.size() != 6 || dc != 8 || bb != 0 || (wa.size() == 6 && (wa[0] != 1010 || wa[5] != 1212))) begin
            n_fail++;
            $display("FAIL rstmid_restart: writes=%0d done_cyc=%0d busybad=%0d expected 6 8 0",
                     wa.size(), dc, bb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_empty();
        test_cpu_arbitration();
        test_full_screen();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
